fb_writer: RTL
==============

# fb_writer

Frame-buffer writer: the write-side counterpart of the VGA pixel fetch path. It accepts an 8-bit pixel stream over a valid/ready handshake and writes one IMG_W × IMG_H image, row-major, into the 8-bit dual-port frame-buffer RAM. The VGA display reads that RAM through `rdaddress`/`q`. The block drives the RAM write port (`wraddress`/`data`/`wren`) and reports `busy`/`done` to the loader, which is either the PISA core or the host interface.

## Interface
Parameters:
- `IMG_W`, default 256: pixels per row, 1..512.
- `IMG_H`, default 256: rows per frame, 1..512.
- `ADDR_W`, default 18: RAM address width.

Ports:
- `clk` in, 1: single clock for all logic.
- `reset` in, 1: asynchronous, active-low. Asserting it (0) clears all state immediately.
- `start` in, 1: one-cycle request to load one frame.
- `base_addr` in, ADDR_W: first RAM address of the image. Sampled on an accepted `start`.
- `in_valid` in, 1: `in_data` holds a pixel.
- `in_data` in, 8: pixel value.
- `in_ready` out, 1: the block accepts a pixel this cycle.
- `wraddress` out, ADDR_W: RAM write address.
- `data` out, 8: RAM write data.
- `wren` out, 1: RAM write enable.
- `busy` out, 1: a frame load is in progress.
- `done` out, 1: one-cycle pulse after the last write of a frame.
- `vsync` in, 1: display vsync, active-low. Present only with `FB_WRITER_VSYNC_GATE_EN`.

## Operation
- FSM states: IDLE, ARM, WRITE, FLUSH.
- IDLE:
  - `start`=1 latches `base_addr` into the address register.
  - Column and row counters clear to 0.
  - Next state is ARM when `FB_WRITER_VSYNC_GATE_EN` is defined, otherwise WRITE.
- ARM: stays until a vsync falling edge is detected, then moves to WRITE.
- WRITE:
  - `in_ready`=1.
  - A beat is accepted on `in_valid && in_ready`. Each accepted beat registers `wraddress`=current address, `data`=`in_data`, `wren`=1.
  - After each beat the address increments by 1, and the column counter increments.
  - When column = IMG_W−1, the column wraps to 0 and the row increments.
  - The beat accepted at row IMG_H−1, column IMG_W−1 moves the FSM to FLUSH.
- FLUSH: lasts one cycle, issues the last write, asserts `done`=1, then returns to IDLE.
- `busy`=1 in ARM, WRITE and FLUSH.
- `start` while `busy`=1 is ignored. It is neither queued nor a restart.
- `in_valid` low in WRITE is a stall: no write, counters hold. Gaps of any length are legal.
- `in_valid` in IDLE or ARM is not consumed, because `in_ready`=0.
- Arithmetic: the address is ADDR_W bits and wraps modulo 2^ADDR_W, with no error. Column and row counters are 9 bits.
- Frame size IMG_W·IMG_H ≤ 2^ADDR_W. Larger sizes are a configuration error, checked by an elaboration assertion.
- Reset asserted mid-frame:
  - State returns to IDLE and all outputs go to 0.
  - Any partially written frame is left in RAM. No cleanup.
- Reset values: `in_ready`=0, `wraddress`=0, `data`=0, `wren`=0, `busy`=0, `done`=0.

## Timing
- Write latency: accept in cycle N → `wren`/`wraddress`/`data` valid in cycle N+1, for exactly one cycle per beat.
- Throughput: 1 pixel/clk. A frame with no stalls takes IMG_W·IMG_H accept cycles.
- `in_ready` is a registered function of state only. It does not depend on `in_valid` combinationally.
- Without the vsync macro:
  - `start` at cycle S → `busy`=1 and `in_ready`=1 at S+1.
  - Last accept at cycle L → last `wren` at L+1, with `done`=1 in the same cycle. `busy`=0 and `in_ready`=0 at L+2.
- `in_ready` drops at L+1, so no beat is accepted after the last pixel.
- `done` and `busy`=1 are never both asserted together with `in_ready`=1.

## Configuration
- `FB_WRITER_VSYNC_GATE_EN` defined:
  - The `vsync` port exists and passes through a 2-flop synchronizer.
  - A vsync falling edge means the synchronized `vsync` was 1 in the previous cycle and is 0 in the current one.
  - The writer waits in ARM for that edge, so a frame load starts at a frame boundary and tearing is avoided.
  - Entering WRITE takes 3 clk after the raw edge, at minimum.
- Not defined: no `vsync` port, ARM is never entered, and `start` goes directly to WRITE.

## Test plan
- IMG_W=4, IMG_H=2, `base_addr`=0x00100, continuous `in_valid` with data 0x10..0x17 → 8 writes at 0x00100..0x00107, data 0x10..0x17. `done` pulses with the write to 0x00107. `busy` falls one cycle later.
- Same frame with `in_valid` toggling every other cycle → identical write sequence, no duplicate or skipped addresses, `done` exactly once.
- `base_addr`=0x3FFFE, 4 pixels → writes to 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- `start` re-pulsed mid-frame → ignored, address sequence continues unchanged. Reset asserted after 3 writes → all outputs 0 immediately. A new `start` then restarts from the new `base_addr`.
- With `FB_WRITER_VSYNC_GATE_EN`: `start` issued, vsync held high for 100 cycles → `in_ready`=0 and `busy`=1 throughout. Vsync falls → `in_ready`=1 within 3–4 cycles.
- Default 256×256, random stalls → 65536 writes, final address `base_addr`+0xFFFF, RAM contents match the stream.

Source files
------------

// File: rtl/fb_writer.sv
// fb_writer: streams one IMG_W x IMG_H 8-bit image, row-major, into the
// frame-buffer RAM write port starting at base_addr.
// Optional macro FB_WRITER_VSYNC_GATE_EN adds a vsync input; the writer then
// waits for a display vsync falling edge before accepting pixels.
module fb_writer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic              busy,
  output logic              done
`ifdef FB_WRITER_VSYNC_GATE_EN
  ,
  input  logic              vsync
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

`ifdef FB_WRITER_VSYNC_GATE_EN
  localparam logic [1:0] S_START = S_ARM;
`else
  localparam logic [1:0] S_START = S_WRITE;
`endif

  localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);

  localparam longint unsigned FRAME_PIX = longint'(IMG_W) * longint'(IMG_H);
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  generate
    if (IMG_W < 1 || IMG_W > 512 || IMG_H < 1 || IMG_H > 512) begin : g_bad_dims
      $error("fb_writer: IMG_W and IMG_H must be in 1..512");
    end
    if (FRAME_PIX > ADDR_SPAN) begin : g_frame_too_big
      $error("fb_writer: IMG_W*IMG_H exceeds 2**ADDR_W");
    end
  endgenerate

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        col;
  logic [8:0]        row;
  logic              accept;
  logic              last_beat;
  logic              vs_fall;

`ifdef FB_WRITER_VSYNC_GATE_EN
  logic vs_meta;
  logic vs_sync;
  logic vs_prev;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_fall = vs_prev & ~vs_sync;
`else
  assign vs_fall = 1'b0;
`endif

  // Outputs decoded from the state register only, never from in_valid
  assign in_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FLUSH);
  assign accept    = in_valid & in_ready;
  assign last_beat = (col == COL_LAST) && (row == ROW_LAST);

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_START;
      S_ARM:   if (vs_fall) next_state = S_WRITE;
      S_WRITE: if (accept && last_beat) next_state = S_FLUSH;
      S_FLUSH: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Address/counter bookkeeping and the registered RAM write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      col       <= '0;
      row       <= '0;
      wraddress <= '0;
      data      <= '0;
      wren      <= 1'b0;
    end else begin
      wren <= 1'b0;
      if (state == S_IDLE) begin
        col <= '0;
        row <= '0;
        if (start) addr <= base_addr;
      end else if (accept) begin
        wraddress <= addr;
        data      <= in_data;
        wren      <= 1'b1;
        addr      <= addr + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
    end
  end

endmodule
